// File: rtl/mips_mc_pkg.sv
// Shared constants for the multicycle MIPS main control FSM: state codes,
// opcodes and the datapath mux/ALU encodings.
package mips_mc_pkg;

  // State codes (visible on the STATE debug port, so they are fixed values)
  localparam logic [3:0] StInit   = 4'd0;
  localparam logic [3:0] StFetch  = 4'd1;
  localparam logic [3:0] StDecode = 4'd2;
  localparam logic [3:0] StMemAdr = 4'd3;
  localparam logic [3:0] StMemRd  = 4'd4;
  localparam logic [3:0] StMemWb  = 4'd5;
  localparam logic [3:0] StMemWr  = 4'd6;
  localparam logic [3:0] StRExe   = 4'd7;
  localparam logic [3:0] StRWb    = 4'd8;
  localparam logic [3:0] StBeqEx  = 4'd9;
  localparam logic [3:0] StAddiEx = 4'd10;
  localparam logic [3:0] StAddiWb = 4'd11;
  localparam logic [3:0] StJEx    = 4'd12;

  // Opcodes from IR[31:26]
  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpJ     = 6'b000010;

  // ALUOP encodings
  localparam logic [1:0] AluAdd   = 2'b00;
  localparam logic [1:0] AluSub   = 2'b01;
  localparam logic [1:0] AluFunct = 2'b10;

  // ALUSRCB encodings
  localparam logic [1:0] SrcbB     = 2'b00;
  localparam logic [1:0] SrcbFour  = 2'b01;
  localparam logic [1:0] SrcbImm   = 2'b10;
  localparam logic [1:0] SrcbImmSh = 2'b11;

  // PCSOURCE encodings
  localparam logic [1:0] PcsrcAlu    = 2'b00;
  localparam logic [1:0] PcsrcAluOut = 2'b01;
  localparam logic [1:0] PcsrcJump   = 2'b10;

endpackage

// File: rtl/mips_mc_outdec.sv
// Moore output decoder: maps the current state code to the full datapath
// control vector. Purely combinational.
module mips_mc_outdec
  import mips_mc_pkg::*;
(
  input  logic [3:0] state,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source
);

  // Every control defaults low; each state raises only what it needs
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SrcbB;
    alu_op        = AluAdd;
    pc_source     = PcsrcAlu;
    case (state)
      StFetch: begin
        mem_read  = 1'b1;
        ir_write  = 1'b1;
        alu_src_b = SrcbFour;
        pc_write  = 1'b1;
      end
      StDecode: alu_src_b = SrcbImmSh;
      StMemAdr, StAddiEx: begin
        alu_src_a = 1'b1;
        alu_src_b = SrcbImm;
      end
      StMemRd: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      StMemWr: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
      end
      StMemWb: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      StRExe: begin
        alu_src_a = 1'b1;
        alu_op    = AluFunct;
      end
      StRWb: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      StAddiWb: reg_write = 1'b1;
      StBeqEx: begin
        alu_src_a     = 1'b1;
        alu_op        = AluSub;
        pc_write_cond = 1'b1;
        pc_source     = PcsrcAluOut;
      end
      StJEx: begin
        pc_write  = 1'b1;
        pc_source = PcsrcJump;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mips_mc_control.sv
// Main control FSM of the multicycle MIPS datapath: state register, opcode
// driven next-state logic, sticky illegal-opcode flag and retired counter.
module mips_mc_control
  import mips_mc_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [5:0]       OPCODE,
  output logic             PCWRITE,
  output logic             PCWRITECOND,
  output logic             IORD,
  output logic             MEMREAD,
  output logic             MEMWRITE,
  output logic             IRWRITE,
  output logic             MEMTOREG,
  output logic             REGDST,
  output logic             REGWRITE,
  output logic             ALUSRCA,
  output logic [1:0]       ALUSRCB,
  output logic [1:0]       ALUOP,
  output logic [1:0]       PCSOURCE,
  output logic             ILLEGAL,
  output logic [CNT_W-1:0] RETIRED,
  output logic [3:0]       STATE
);

  logic [3:0]       state_q, state_d;
  logic             illegal_q, illegal_set;
  logic [CNT_W-1:0] retired_q;
  logic             retire;

  // Next state, plus the retire / illegal-opcode events for this edge
  always_comb begin
    state_d     = StInit;
    retire      = 1'b0;
    illegal_set = 1'b0;
    case (state_q)
      StInit:  state_d = StFetch;
      StFetch: state_d = StDecode;
      StDecode: begin
        case (OPCODE)
          OpLw, OpSw: state_d = StMemAdr;
          OpRtype:    state_d = StRExe;
          OpBeq:      state_d = StBeqEx;
          OpAddi:     state_d = StAddiEx;
          OpJ:        state_d = StJEx;
          default: begin
            state_d     = StFetch;
            illegal_set = 1'b1;
          end
        endcase
      end
      StMemAdr: begin
        // Opcode is held in IR, so it is still LW or SW here; anything else
        // abandons the instruction without retiring it.
        if (OPCODE == OpLw)      state_d = StMemRd;
        else if (OPCODE == OpSw) state_d = StMemWr;
        else                     state_d = StFetch;
      end
      StMemRd:  state_d = StMemWb;
      StRExe:   state_d = StRWb;
      StAddiEx: state_d = StAddiWb;
      StMemWb, StMemWr, StRWb, StAddiWb, StBeqEx, StJEx: begin
        state_d = StFetch;
        retire  = 1'b1;
      end
      default: state_d = StInit;
    endcase
  end

  // State, sticky flag and counter; reset aborts any in-flight instruction
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= StInit;
      illegal_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      if (illegal_set) illegal_q <= 1'b1;
      if (retire)      retired_q <= retired_q + CNT_W'(1);
    end
  end

  mips_mc_outdec u_outdec (
    .state         (state_q),
    .pc_write      (PCWRITE),
    .pc_write_cond (PCWRITECOND),
    .i_or_d        (IORD),
    .mem_read      (MEMREAD),
    .mem_write     (MEMWRITE),
    .ir_write      (IRWRITE),
    .mem_to_reg    (MEMTOREG),
    .reg_dst       (REGDST),
    .reg_write     (REGWRITE),
    .alu_src_a     (ALUSRCA),
    .alu_src_b     (ALUSRCB),
    .alu_op        (ALUOP),
    .pc_source     (PCSOURCE)
  );

  assign ILLEGAL = illegal_q;
  assign RETIRED = retired_q;
  assign STATE   = state_q;

endmodule

// File: tb/tb_mips_mc_control.sv
// Bench for mips_mc_control: a path-based instruction model checked every
// cycle, plus directed literal checks. A second instance with a 2-bit
// counter runs on the same stimulus to exercise counter wrap.
module tb_mips_mc_control;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [5:0] OPCODE = 6'b000000;

  logic        pcw, pcwc, iord, mr, mw, irw, m2r, rdst, rw, asa, ill;
  logic [1:0]  asb, aop, pcs;
  logic [15:0] ret;
  logic [3:0]  st;

  logic        pcw2, pcwc2, iord2, mr2, mw2, irw2, m2r2, rdst2, rw2, asa2, ill2;
  logic [1:0]  asb2, aop2, pcs2, ret2;
  logic [3:0]  st2;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  mips_mc_control #(.CNT_W(16)) dut (
    .CLK(CLK), .RST(RST), .OPCODE(OPCODE),
    .PCWRITE(pcw), .PCWRITECOND(pcwc), .IORD(iord), .MEMREAD(mr), .MEMWRITE(mw),
    .IRWRITE(irw), .MEMTOREG(m2r), .REGDST(rdst), .REGWRITE(rw), .ALUSRCA(asa),
    .ALUSRCB(asb), .ALUOP(aop), .PCSOURCE(pcs), .ILLEGAL(ill), .RETIRED(ret),
    .STATE(st)
  );

  mips_mc_control #(.CNT_W(2)) dut2 (
    .CLK(CLK), .RST(RST), .OPCODE(OPCODE),
    .PCWRITE(pcw2), .PCWRITECOND(pcwc2), .IORD(iord2), .MEMREAD(mr2),
    .MEMWRITE(mw2), .IRWRITE(irw2), .MEMTOREG(m2r2), .REGDST(rdst2),
    .REGWRITE(rw2), .ALUSRCA(asa2), .ALUSRCB(asb2), .ALUOP(aop2),
    .PCSOURCE(pcs2), .ILLEGAL(ill2), .RETIRED(ret2), .STATE(st2)
  );

  // Control vector order:
  // pcw pcwc iord mr mw irw m2r rdst rw asa asb[2] aop[2] pcs[2]
  function automatic logic [15:0] cv(logic a, logic b, logic c, logic d, logic e,
                                     logic f, logic g, logic h, logic i, logic j,
                                     logic [1:0] k, logic [1:0] l, logic [1:0] m);
    return {a, b, c, d, e, f, g, h, i, j, k, l, m};
  endfunction

  // Expected controls per state, straight from the state/output table
  function automatic logic [15:0] exp_ctrl(int s);
    case (s)
      1:       return cv(1, 0, 0, 1, 0, 1, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00);
      2:       return cv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 2'b00);
      3, 10:   return cv(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 2'b00);
      4:       return cv(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00);
      5:       return cv(0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 2'b00);
      6:       return cv(0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00);
      7:       return cv(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b10, 2'b00);
      8:       return cv(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00);
      9:       return cv(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 2'b01);
      11:      return cv(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00);
      12:      return cv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b10);
      default: return 16'h0000;
    endcase
  endfunction

  logic [15:0] act_ctrl, act_ctrl2;
  assign act_ctrl  = {pcw, pcwc, iord, mr, mw, irw, m2r, rdst, rw, asa, asb, aop, pcs};
  assign act_ctrl2 = {pcw2, pcwc2, iord2, mr2, mw2, irw2, m2r2, rdst2, rw2, asa2,
                      asb2, aop2, pcs2};

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: each legal opcode expands to the list of states it visits after
  // DECODE; when the list runs dry the instruction retires.
  int m_state = 0;
  bit m_ill = 0;
  int unsigned m_ret = 0;
  int m_path[$];
  bit m_live = 0;

  always @(posedge CLK) begin
    m_live = 1'b1;
    if (RST) begin
      m_state = 0;
      m_ill   = 0;
      m_ret   = 0;
      m_path.delete();
    end else if (m_state == 0) begin
      m_state = 1;
    end else if (m_state == 1) begin
      m_state = 2;
    end else if (m_state == 2) begin
      case (OPCODE)
        6'b100011: m_path = {3, 4, 5};
        6'b101011: m_path = {3, 6};
        6'b000000: m_path = {7, 8};
        6'b000100: m_path = {9};
        6'b001000: m_path = {10, 11};
        6'b000010: m_path = {12};
        default:   m_path.delete();
      endcase
      if (m_path.size() > 0) begin
        m_state = m_path.pop_front();
      end else begin
        m_state = 1;
        m_ill   = 1;
      end
    end else if (m_path.size() > 0) begin
      m_state = m_path.pop_front();
    end else begin
      m_state = 1;
      m_ret   = m_ret + 1;
    end
  end

  // Per-cycle comparison of both instances against the model
  always @(negedge CLK) begin
    if (m_live) begin
      check("state", 32'(st), 32'(m_state));
      check("ctrl", 32'(act_ctrl), 32'(exp_ctrl(m_state)));
      check("illegal", 32'(ill), 32'(m_ill));
      check("retired", 32'(ret), m_ret % 65536);
      check("state_w2", 32'(st2), 32'(m_state));
      check("ctrl_w2", 32'(act_ctrl2), 32'(exp_ctrl(m_state)));
      check("retired_w2", 32'(ret2), m_ret % 4);
      check("rd_wr_excl", 32'(mr & mw), 32'd0);
    end
  end

  task automatic tick();
    @(negedge CLK);
  endtask

  // Starts at a negedge in FETCH; returns cycles spent until back in FETCH
  task automatic run_instr(input logic [5:0] op, output int cycles, output int rw_pulses);
    OPCODE    = op;
    cycles    = 1;
    rw_pulses = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (st == 4'd1) return;
      cycles++;
      if (rw) rw_pulses++;
    end
    check("instr_timeout", 32'(st), 32'd1);
  endtask

  int cyc, pulses;

  initial begin
    // Reset held for two cycles
    RST = 1'b1;
    repeat (2) tick();
    check("rst_state", 32'(st), 32'd0);
    check("rst_ctrl", 32'(act_ctrl), 32'd0);
    check("rst_retired", 32'(ret), 32'd0);
    RST = 1'b0;
    tick();
    check("fetch_state", 32'(st), 32'd1);
    check("fetch_ctrl", 32'(act_ctrl), 32'h9410);

    // LW: 1,2,3,4,5 then back to 1; one REGWRITE pulse in MEMWB
    run_instr(6'b100011, cyc, pulses);
    check("lw_cycles", 32'(cyc), 32'd5);
    check("lw_regwrite", 32'(pulses), 32'd1);
    check("lw_retired", 32'(ret), 32'd1);

    // RTYPE, ADDI, SW, BEQ, J
    run_instr(6'b000000, cyc, pulses);
    check("rtype_cycles", 32'(cyc), 32'd4);
    check("rtype_regwrite", 32'(pulses), 32'd1);
    run_instr(6'b001000, cyc, pulses);
    check("addi_cycles", 32'(cyc), 32'd4);
    check("addi_regwrite", 32'(pulses), 32'd1);
    run_instr(6'b101011, cyc, pulses);
    check("sw_cycles", 32'(cyc), 32'd4);
    check("sw_regwrite", 32'(pulses), 32'd0);
    run_instr(6'b000100, cyc, pulses);
    check("beq_cycles", 32'(cyc), 32'd3);
    run_instr(6'b000010, cyc, pulses);
    check("j_cycles", 32'(cyc), 32'd3);
    check("seq_retired", 32'(ret), 32'd6);

    // Illegal opcode: back to FETCH after DECODE, flag set, no retire
    run_instr(6'b111111, cyc, pulses);
    check("ill_cycles", 32'(cyc), 32'd2);
    check("ill_flag", 32'(ill), 32'd1);
    check("ill_retired", 32'(ret), 32'd6);
    run_instr(6'b000000, cyc, pulses);
    check("post_ill_cycles", 32'(cyc), 32'd4);
    check("post_ill_flag", 32'(ill), 32'd1);
    check("post_ill_retired", 32'(ret), 32'd7);

    // Reset while in MEMRD
    OPCODE = 6'b100011;
    repeat (3) tick();
    check("pre_rst_memrd", 32'(st), 32'd4);
    RST = 1'b1;
    tick();
    check("mid_rst_state", 32'(st), 32'd0);
    check("mid_rst_regwrite", 32'(rw), 32'd0);
    check("mid_rst_illegal", 32'(ill), 32'd0);
    check("mid_rst_retired", 32'(ret), 32'd0);
    RST = 1'b0;
    tick();
    check("post_rst_fetch", 32'(st), 32'd1);

    // Counter wrap on the 2-bit instance: 1,2,3,0,1
    for (int k = 0; k < 5; k++) begin
      logic [1:0] want;
      want = 2'((k + 1) % 4);
      run_instr(6'b000010, cyc, pulses);
      check("wrap_retired_w2", 32'(ret2), 32'(want));
    end
    check("wrap_retired_w16", 32'(ret), 32'd5);

    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
